spi_reg_ctrl: RTL and testbench

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

---
 rtl/spi_reg_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_ctrl.sv
// SPI (mode 0) slave that writes a small bank of 8-bit control registers.
// Latency: register and wr_pulse update 1 clk after the synchronized ncs rising edge.
// Backpressure: none; SPI is a push interface, so frames that are malformed are dropped.
//
// Ports:
//   clk, rst            - system clock, synchronous active-high reset
//   ncs, sclk, copi     - asynchronous SPI inputs (sclk at most clk/8)
//   cipo                - SPI read data, only with SPI_READBACK_EN defined
//   en_reg_out_*, en_reg_pwm_*, pwm_duty_cycle - registers at addresses 0x00..0x04
//   wr_pulse            - one-clk strobe on every committed write
// Build option: define SPI_READBACK_EN to add the cipo port and read shifter.
// Frame: 16 bits MSB first, {rw(1=write), addr[6:0], data[7:0]}.

`timescale 1ns/1ps

module spi_reg_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ncs,
    input  logic       sclk,
    input  logic       copi,
`ifdef SPI_READBACK_EN
    output logic       cipo,
`endif
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_pulse
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, DISCARD} state_t;

    state_t                 state, state_nxt;

    logic [SYNC_STAGES-1:0] ncs_sync, sclk_sync, copi_sync;
    logic [SYNC_STAGES-1:0] settle;
    logic                   ncs_s, sclk_s, copi_s;
    logic                   ncs_d, sclk_d;
    logic                   ncs_hi_seen;
    logic                   ncs_fall, ncs_rise, sclk_rise;

    logic [4:0]             bit_cnt, cnt_upd;
    logic [15:0]            shreg, sh_nxt, frame_nxt;

    logic                   cnt_clr, shift_en, commit_go, wr_go;

    // ---------------------------------------------------------------
    // Input synchronizers and edge detection
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ncs_sync    <= '1;
            sclk_sync   <= '0;
            copi_sync   <= '0;
            ncs_d       <= 1'b1;
            sclk_d      <= 1'b0;
            settle      <= '0;
            ncs_hi_seen <= 1'b0;
        end else begin
            ncs_sync    <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            copi_sync   <= {copi_sync[SYNC_STAGES-2:0], copi};
            ncs_d       <= ncs_s;
            sclk_d      <= sclk_s;
            settle      <= {settle[SYNC_STAGES-2:0], 1'b1};
            // Once the chain has refilled with real samples, a frame may
            // only start after ncs has been seen high. This stops the tail
            // of a frame interrupted by reset from being taken as a new one.
            if (settle[SYNC_STAGES-1] && ncs_s)
                ncs_hi_seen <= 1'b1;
        end
    end

    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];

    assign ncs_fall  = ncs_d & ~ncs_s & ncs_hi_seen;
    assign ncs_rise  = ~ncs_d & ncs_s;
    assign sclk_rise = ~sclk_d & sclk_s;

    // sclk is counted before the ncs rule is applied when both edges coincide.
    assign cnt_upd   = bit_cnt + {4'd0, sclk_rise};
    assign sh_nxt    = {shreg[14:0], copi_s};
    assign frame_nxt = shift_en ? sh_nxt : shreg;

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ncs_fall)
                    state_nxt = SHIFT;
            end
            SHIFT: begin
                if (sclk_rise && (bit_cnt == 5'd16))
                    state_nxt = DISCARD;
                else if (ncs_rise)
                    state_nxt = (cnt_upd == 5'd16) ? COMMIT : IDLE;
            end
            COMMIT:  state_nxt = IDLE;
            DISCARD: begin
                if (ncs_s)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs (datapath controls)
    // ---------------------------------------------------------------
    always_comb begin
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        commit_go = 1'b0;
        case (state)
            IDLE:  cnt_clr = ncs_fall;
            SHIFT: begin
                shift_en  = sclk_rise;
                commit_go = (state_nxt == COMMIT);
            end
            default: ;
        endcase
    end

    // Registers load on entry to COMMIT so the new value and wr_pulse are
    // both visible during the single COMMIT cycle.
    assign wr_go = commit_go && frame_nxt[15] && (frame_nxt[14:8] <= MAX_ADDR);

    // ---------------------------------------------------------------
    // Bit counter and shift register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (cnt_clr) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (shift_en) begin
            bit_cnt <= cnt_upd;
            shreg   <= sh_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Register bank
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
            wr_pulse        <= 1'b0;
        end else begin
            wr_pulse <= wr_go;
            if (wr_go) begin
                case (frame_nxt[14:8])
                    7'h00:   en_reg_out_7_0  <= frame_nxt[7:0];
                    7'h01:   en_reg_out_15_8 <= frame_nxt[7:0];
                    7'h02:   en_reg_pwm_7_0  <= frame_nxt[7:0];
                    7'h03:   en_reg_pwm_15_8 <= frame_nxt[7:0];
                    7'h04:   pwm_duty_cycle  <= frame_nxt[7:0];
                    default: ;
                endcase
            end
        end
    end

`ifdef SPI_READBACK_EN
    // ---------------------------------------------------------------
    // Read-back shifter
    // ---------------------------------------------------------------
    logic [7:0] rd_mux, out_sh;
    logic       rd_active, rd_load, sclk_fall;

    assign sclk_fall = sclk_d & ~sclk_s;

    // After the 8th bit the shifter already holds {rw, addr}.
    assign rd_load = shift_en && (cnt_upd == 5'd8) && !sh_nxt[7]
                     && (sh_nxt[6:0] <= MAX_ADDR);

    always_comb begin
        rd_mux = '0;
        case (sh_nxt[6:0])
            7'h00:   rd_mux = en_reg_out_7_0;
            7'h01:   rd_mux = en_reg_out_15_8;
            7'h02:   rd_mux = en_reg_pwm_7_0;
            7'h03:   rd_mux = en_reg_pwm_15_8;
            7'h04:   rd_mux = pwm_duty_cycle;
            default: rd_mux = '0;
        endcase
    end

    // The falling edge that follows the 8th rising edge must not shift:
    // the controller samples data bit 7 on the 9th rising edge, so the
    // shifter only advances once bit_cnt has reached 9.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_sh    <= '0;
            rd_active <= 1'b0;
        end else if ((state != SHIFT) || ncs_s) begin
            out_sh    <= '0;
            rd_active <= 1'b0;
        end else if (rd_load) begin
            out_sh    <= rd_mux;
            rd_active <= 1'b1;
        end else if (rd_active && sclk_fall && (bit_cnt >= 5'd9)) begin
            out_sh    <= {out_sh[6:0], 1'b0};
        end
    end

    assign cipo = rd_active & out_sh[7];
`endif

endmodule

// File: tb/tb_spi_reg_ctrl.sv
`timescale 1ns/1ps

module tb_spi_reg_ctrl;

    localparam int SCLK_HALF = 8;   // clk cycles per sclk half period

    logic       clk = 1'b0;
    logic       rst, ncs, sclk, copi;
`ifdef SPI_READBACK_EN
    logic       cipo;
`endif
    logic [7:0] r0, r1, r2, r3, r4;
    logic       wr_pulse;

    spi_reg_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .ncs             (ncs),
        .sclk            (sclk),
        .copi            (copi),
`ifdef SPI_READBACK_EN
        .cipo            (cipo),
`endif
        .en_reg_out_7_0  (r0),
        .en_reg_out_15_8 (r1),
        .en_reg_pwm_7_0  (r2),
        .en_reg_pwm_15_8 (r3),
        .pwm_duty_cycle  (r4),
        .wr_pulse        (wr_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] model [5];
    int         checks      = 0;
    int         failures    = 0;
    int         pulse_cnt   = 0;
    int         long_pulses = 0;
    int         exp_pulses  = 0;
    logic       pulse_prev  = 1'b0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dut_reg(input int a);
        case (a)
            0:       return r0;
            1:       return r1;
            2:       return r2;
            3:       return r3;
            default: return r4;
        endcase
    endfunction

    // Write monitor: each strobe pops the oldest expected write and checks
    // that the addressed register already shows the new data.
    always @(negedge clk) begin
        if (wr_pulse) begin
            pulse_cnt++;
            if (pulse_prev)
                long_pulses++;
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk_val("wr_data", {24'd0, dut_reg(int'(mon_e.addr))}, {24'd0, mon_e.data});
            end
        end
        pulse_prev = wr_pulse;
    end

    // Reference model: only full 16-bit write frames to 0..4 commit.
    task automatic model_frame(input logic [31:0] word, input int nbits);
        logic [15:0] f;
        f = word[15:0];
        if (nbits == 16 && f[15] && f[14:8] <= 7'h04) begin
            model[f[14:8]] = f[7:0];
            exp_q.push_back('{addr: f[14:8], data: f[7:0]});
            exp_pulses++;
        end
    endtask

    task automatic spi_xfer(input logic [31:0] word, input int nbits, input int rst_after,
                            output logic [15:0] rx);
        rx = '0;
        @(negedge clk);
        ncs = 1'b0;
        repeat (SCLK_HALF) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = word[i];
            repeat (SCLK_HALF) @(negedge clk);
`ifdef SPI_READBACK_EN
            rx = {rx[14:0], cipo};
`endif
            sclk = 1'b1;
            repeat (SCLK_HALF) @(negedge clk);
            sclk = 1'b0;
            if ((nbits - i) == rst_after) begin
                rst = 1'b1;
                for (int a = 0; a < 5; a++) model[a] = 8'h00;
                repeat (3) @(negedge clk);
                rst = 1'b0;
            end
        end
        copi = 1'b0;
        repeat (SCLK_HALF) @(negedge clk);
        ncs = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        for (int a = 0; a < 5; a++)
            chk_val($sformatf("%s_reg%0d", tag, a), {24'd0, dut_reg(a)}, {24'd0, model[a]});
        chk_val({tag, "_pulses"}, pulse_cnt, exp_pulses);
        chk_val({tag, "_long_pulse"}, long_pulses, 0);
        chk_val({tag, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic run_frame(input string tag, input logic [31:0] word, input int nbits,
                             input int rst_after, output logic [15:0] rx);
        if (rst_after < 0)
            model_frame(word, nbits);
        spi_xfer(word, nbits, rst_after, rx);
        check_all(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rx;
        logic [6:0]  ra;
        logic [7:0]  rd;

        for (int a = 0; a < 5; a++) model[a] = 8'h00;
        rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
        repeat (5) @(negedge clk);
        check_all("reset");
        chk_val("reset_wr_pulse", {31'd0, wr_pulse}, 0);
`ifdef SPI_READBACK_EN
        chk_val("reset_cipo", {31'd0, cipo}, 0);
`endif
        rst = 1'b0;
        repeat (5) @(negedge clk);

        run_frame("duty",  32'h8455, 16, -1, rx);
        run_frame("out_lo", 32'h80FF, 16, -1, rx);
        run_frame("out_hi", 32'h81AA, 16, -1, rx);
        run_frame("pwm_lo", 32'h82F0, 16, -1, rx);
        run_frame("pwm_hi", 32'h830F, 16, -1, rx);
        run_frame("bad_addr", 32'h8712, 16, -1, rx);
        run_frame("short15", 32'h8466 >> 1, 15, -1, rx);
        run_frame("long17", {15'd0, 16'h8466, 1'b1}, 17, -1, rx);
        run_frame("after_bad", 32'h8477, 16, -1, rx);
        run_frame("read_frame", 32'h0412, 16, -1, rx);

        for (int k = 0; k < 4; k++) begin
            ra = 7'($urandom_range(0, 5));
            rd = 8'($urandom_range(0, 255));
            run_frame("rand", {16'd0, 1'b1, ra, rd}, 16, -1, rx);
        end

        run_frame("mid_reset", 32'h8033, 16, 8, rx);
        run_frame("post_reset", 32'h8033, 16, -1, rx);

`ifdef SPI_READBACK_EN
        run_frame("rb_write", 32'h8299, 16, -1, rx);
        run_frame("rb_read", 32'h0200, 16, -1, rx);
        chk_val("rb_data", {24'd0, rx[7:0]}, 32'h99);
        chk_val("rb_cmd_phase", {24'd0, rx[15:8]}, 0);
        chk_val("rb_cipo_idle", {31'd0, cipo}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
